// File: rtl/axi_burst_addr_gen.sv
// AXI burst to per-beat SRAM byte address sequencer (FIXED/INCR/WRAP, error flagging).
// Latency 1 from command handshake to first beat; beat outputs hold while beat_ready is low.
module axi_burst_addr_gen #(
    parameter int ADDR_WIDTH     = 32,
    parameter int OUT_ADDR_WIDTH = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [2:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [OUT_ADDR_WIDTH-1:0] beat_addr,
    output logic [2:0]                beat_size,
    output logic                      beat_last,
    output logic                      beat_err
);

    typedef enum logic {IDLE, BURST} state_t;
    typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_t;

    typedef struct packed {
        mode_t      mode;
        logic       err;
        logic [7:0] len;
        logic [1:0] step_lg;
        logic [2:0] size;
    } ctx_t;

    state_t                    state_q, state_d;
    ctx_t                      ctx_q;
    logic [7:0]                cnt_q;
    logic [OUT_ADDR_WIDTH-1:0] addr_q;

    logic                      cmd_fire, beat_fire, last;
    logic                      size_bad, wrap_len_ok, misalign, wrap_bad, cmd_err;
    logic [7:0]                size_mask;
    mode_t                     cmd_mode;
    logic [1:0]                cmd_step_lg;
    logic [OUT_ADDR_WIDTH-1:0] step, wrap_mask, incr_addr, wrap_addr, next_addr;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat_fire = beat_valid && beat_ready;
    assign last      = (cnt_q == ctx_q.len);

    // Command legality; anything illegal still sequences, as INCR unless FIXED.
    always_comb begin
        size_bad    = (cmd_size > 3'd2);
        wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                      (cmd_len == 8'd7) || (cmd_len == 8'd15);
        size_mask   = (8'd1 << cmd_size) - 8'd1;
        misalign    = |(cmd_addr[7:0] & size_mask);
        wrap_bad    = (cmd_burst == 2'b10) && (!wrap_len_ok || misalign);
        cmd_err     = size_bad || (cmd_burst == 2'b11) || wrap_bad;
        cmd_step_lg = size_bad ? 2'd2 : cmd_size[1:0];
        if (cmd_burst == 2'b00)
            cmd_mode = MODE_FIXED;
        else if (cmd_burst == 2'b10 && !cmd_err)
            cmd_mode = MODE_WRAP;
        else
            cmd_mode = MODE_INCR;
    end

    always_comb begin
        step      = OUT_ADDR_WIDTH'(1) << ctx_q.step_lg;
        incr_addr = (addr_q & ~(step - OUT_ADDR_WIDTH'(1))) + step;
        wrap_mask = ((OUT_ADDR_WIDTH'(ctx_q.len) + OUT_ADDR_WIDTH'(1)) << ctx_q.step_lg)
                    - OUT_ADDR_WIDTH'(1);
        wrap_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
        case (ctx_q.mode)
            MODE_FIXED: next_addr = addr_q;
            MODE_WRAP:  next_addr = wrap_addr;
            default:    next_addr = incr_addr;
        endcase
    end

    // Handshake outputs are masked during reset so an aborted burst emits nothing more.
    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        beat_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = !ARESET;
                if (cmd_valid && !ARESET)
                    state_d = BURST;
            end
            BURST: begin
                beat_valid = !ARESET;
                if (!ARESET && beat_ready && last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= '0;
            ctx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                addr_q <= cmd_addr[OUT_ADDR_WIDTH-1:0];
                cnt_q  <= 8'd0;
                ctx_q  <= '{mode: cmd_mode, err: cmd_err, len: cmd_len,
                           step_lg: cmd_step_lg, size: cmd_size};
            end else if (beat_fire && !last) begin
                cnt_q  <= cnt_q + 8'd1;
                addr_q <= next_addr;
            end
        end
    end

    assign beat_addr = addr_q;
    assign beat_size = ctx_q.size;
    assign beat_last = beat_valid && last;
    assign beat_err  = beat_valid && ctx_q.err;

    generate
        if (ADDR_WIDTH > OUT_ADDR_WIDTH) begin : g_drop_high
            logic unused_high_addr;
            assign unused_high_addr = ^cmd_addr[ADDR_WIDTH-1:OUT_ADDR_WIDTH];
        end
    endgenerate

endmodule

// File: doc/axi_burst_addr_gen.md
AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of the incoming AXI address.
REQ-002 Parameter OUT_ADDR_WIDTH, default 16: width of the per-beat SRAM byte address.
REQ-003 Port ACLK, input, 1: single clock; all logic on rising edge.
REQ-004 Port ARESET, input, 1: reset is synchronous and active-high.
REQ-005 Port cmd_valid, input, 1: burst command valid (AWVALID/ARVALID side).
REQ-006 Port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-007 Port cmd_addr, input, ADDR_WIDTH: start byte address.
REQ-008 Port cmd_len, input, 8: beats minus one.
REQ-009 Port cmd_size, input, 3: bytes per beat = 2^cmd_size.
REQ-010 Port cmd_burst, input, 2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 Port beat_valid, output, 1: beat address valid.
REQ-012 Port beat_ready, input, 1: beat consumed when beat_valid and beat_ready are both high.
REQ-013 Port beat_addr, output, OUT_ADDR_WIDTH: byte address of the current beat; feeds the awaddr/araddr SRAM mux.
REQ-014 Port beat_size, output, 3: registered copy of cmd_size.
REQ-015 Port beat_last, output, 1: high on the final beat of the burst.
REQ-016 Port beat_err, output, 1: high on every beat of an illegal burst; used for SLVERR.

Function
REQ-017 The FSM SHALL have two states. IDLE: cmd_ready=1, beat_valid=0. BURST: cmd_ready=0, beat_valid=1.
REQ-018 In IDLE, a command handshake SHALL latch addr[OUT_ADDR_WIDTH-1:0], len, size, burst and err, clear the beat counter, and move to BURST. beat_valid rises the cycle after the handshake (latency 1).
REQ-019 In BURST with beat_valid&&!beat_ready, beat_addr, beat_last, beat_size and beat_err SHALL hold stable.
REQ-020 On a beat handshake with counter==len, the FSM SHALL return to IDLE. A new command is therefore accepted no earlier than the cycle after the last beat, giving a one-cycle bubble between bursts.
REQ-021 On a beat handshake with counter<len, the counter SHALL increment and beat_addr SHALL advance per REQ-022..REQ-024.
REQ-022 FIXED: beat_addr is unchanged for all beats.
REQ-023 INCR: next = (addr with low cmd_size bits cleared) + 2^size, modulo 2^OUT_ADDR_WIDTH.
  - An unaligned first address is output unchanged; all later beats are aligned.
  - 0xFFFC + 4 wraps to 0x0000.
REQ-024 WRAP: boundary B = (len+1)*2^size; next = (addr & ~(B-1)) | ((addr + 2^size) & (B-1)).
REQ-025 beat_last SHALL equal (counter==len) while in BURST, and 0 otherwise. len=0 gives a single beat with beat_last=1.
REQ-026 err SHALL be set when any of the following holds:
  - cmd_size>2 (wider than the 32-bit SRAM);
  - cmd_burst==11;
  - WRAP with len not in {1,3,7,15};
  - WRAP with a start address not aligned to 2^size.
REQ-027 An illegal burst SHALL still produce len+1 beats with beat_err=1 on each. Address sequencing treats reserved burst and illegal WRAP as INCR; size>2 steps by 4 bytes.
REQ-028 cmd_valid while in BURST SHALL be ignored; the command is held off via cmd_ready=0.
REQ-029 Address bits above OUT_ADDR_WIDTH SHALL be discarded. No 4KB-boundary check is made.

Reset
REQ-030 While ARESET=1 at a clock edge, the following SHALL hold:
  - state=IDLE, counter=0;
  - beat_valid=0, beat_last=0, beat_err=0, beat_addr=0, beat_size=0;
  - cmd_ready=0 during reset and 1 on the first cycle after release.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately, with no further beats. The next command after release starts cleanly.

Verification
REQ-032 INCR: addr 0x0000_1002, size 1, len 3, beat_ready=1 -> beat_addr 0x1002, 0x1004, 0x1006, 0x1008; beat_last only on the 4th beat; beat_err=0.
REQ-033 WRAP: addr 0x0000_0038, size 2, len 3 -> beat_addr 0x38, 0x3C, 0x30, 0x34; beat_last on 0x34.
REQ-034 FIXED with backpressure: addr 0x0000_0200, size 0, len 2, beat_ready toggling 1/0 -> three beats at 0x200; outputs stable on stalled cycles; exactly 3 handshakes.
REQ-035 Errors: size 3, len 1 -> two beats with beat_err=1. WRAP with len 2 -> three beats with beat_err=1, INCR addresses.
REQ-036 Wrap and back-to-back: INCR addr 0x0001_FFFC, size 2, len 1 -> beat_addr 0xFFFC then 0x0000. A second command presented during the last beat is accepted the cycle after.
REQ-037 Reset mid-burst: ARESET pulsed during beat 2 of a len-7 burst -> beat_valid=0 next cycle. A following len-0 command gives one beat with beat_last=1.
